step_profile_ctrl: RTL and testbench

- Trapezoidal motion sequencer that generates the step pulse (CP) and direction (CCW) streams feeding the microstepping Interface block.
- Given a step count and a period envelope, it emits steps at a period that accelerates, cruises and decelerates.
- The Interface REFA/REFB/REFC generation then advances one microstep per CP rising edge.
- Sits between the command/register layer and Interface; it owns CP/CCW exclusively.

---
 rtl/step_profile_ctrl.sv | 173 +++++++++++++++++
 tb/tb_step_profile_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/step_profile_ctrl.sv
// Trapezoidal step sequencer: emits CP/CCW to the microstepping Interface with a
// period that ramps from start_period down to min_period and back up before the last step.
module step_profile_ctrl #(
    parameter int unsigned STEP_W  = 16,
    parameter int unsigned PER_W   = 16,
    parameter int unsigned ACC_W   = 8,
    parameter int unsigned PULSE_W = 4
) (
    input  logic              CLK,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              dir_in,
    input  logic [STEP_W-1:0] steps,
    input  logic [PER_W-1:0]  start_period,
    input  logic [PER_W-1:0]  min_period,
    input  logic [ACC_W-1:0]  accel,
    output logic              CP,
    output logic              CCW,
    output logic              busy,
    output logic              done,
    output logic [STEP_W-1:0] steps_done
);

    typedef enum logic [1:0] {IDLE, ACCEL, CRUISE, DECEL} state_t;

    localparam logic [PER_W-1:0] MIN_FLOOR = PER_W'(2 * PULSE_W);

    state_t            state_q, state_d;
    logic [PER_W-1:0]  ph_q, ph_d;
    logic [PER_W-1:0]  cur_q, cur_d;
    logic [PER_W-1:0]  eff_min_q, eff_min_d;
    logic [PER_W-1:0]  eff_start_q, eff_start_d;
    logic [ACC_W-1:0]  accel_q, accel_d;
    logic [STEP_W-1:0] steps_q, steps_d;
    logic [STEP_W-1:0] cnt_q, cnt_d;
    logic [STEP_W-1:0] ramp_q, ramp_d;
    logic              dir_q, dir_d;
    logic              done_q, done_d;

    logic [PER_W-1:0]  in_min, in_start;
    logic [PER_W:0]    up_sum, dn_diff;
    logic [PER_W-1:0]  per_up, per_dn;
    logic [STEP_W-1:0] ramp_inc, ramp_dec, cnt_inc, remaining;
    logic              last;

    always_comb begin
        in_min   = (min_period > MIN_FLOOR) ? min_period : MIN_FLOOR;
        in_start = (start_period > in_min) ? start_period : in_min;

        // One extra bit so that neither direction can wrap before clamping
        up_sum  = {1'b0, cur_q} + (PER_W+1)'(accel_q);
        dn_diff = {1'b0, cur_q} - (PER_W+1)'(accel_q);
        per_up  = (up_sum > {1'b0, eff_start_q}) ? eff_start_q : up_sum[PER_W-1:0];
        per_dn  = (dn_diff[PER_W] || (dn_diff[PER_W-1:0] < eff_min_q)) ? eff_min_q
                                                                       : dn_diff[PER_W-1:0];

        ramp_inc  = (&ramp_q) ? ramp_q : ramp_q + 1'b1;
        ramp_dec  = (ramp_q == '0) ? '0 : ramp_q - 1'b1;
        cnt_inc   = cnt_q + 1'b1;
        remaining = steps_q - cnt_inc;
        last      = (ph_q == cur_q - PER_W'(1));
    end

    always_comb begin
        state_d     = state_q;
        ph_d        = ph_q;
        cur_d       = cur_q;
        eff_min_d   = eff_min_q;
        eff_start_d = eff_start_q;
        accel_d     = accel_q;
        steps_d     = steps_q;
        cnt_d       = cnt_q;
        ramp_d      = ramp_q;
        dir_d       = dir_q;
        done_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    eff_min_d   = in_min;
                    eff_start_d = in_start;
                    accel_d     = accel;
                    steps_d     = steps;
                    dir_d       = dir_in;
                    cnt_d       = '0;
                    cur_d       = in_start;
                    ramp_d      = '0;
                    ph_d        = '0;
                    if (steps == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = ACCEL;
                    end
                end
            end
            default: begin
                if (last) begin
                    cnt_d = cnt_inc;
                    ph_d  = '0;
                    if ((remaining == '0) || abort) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        case (state_q)
                            ACCEL: begin
                                if (remaining <= ramp_q) begin
                                    state_d = DECEL;
                                    cur_d   = per_up;
                                    ramp_d  = ramp_dec;
                                end else begin
                                    cur_d  = per_dn;
                                    ramp_d = ramp_inc;
                                    if (per_dn == eff_min_q) begin
                                        state_d = CRUISE;
                                    end
                                end
                            end
                            CRUISE: begin
                                if (remaining <= ramp_q) begin
                                    state_d = DECEL;
                                    cur_d   = per_up;
                                    ramp_d  = ramp_dec;
                                end
                            end
                            default: begin
                                cur_d  = per_up;
                                ramp_d = ramp_dec;
                            end
                        endcase
                    end
                end else begin
                    ph_d = ph_q + PER_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!rst) begin
            state_q     <= IDLE;
            ph_q        <= '0;
            cur_q       <= '0;
            eff_min_q   <= '0;
            eff_start_q <= '0;
            accel_q     <= '0;
            steps_q     <= '0;
            cnt_q       <= '0;
            ramp_q      <= '0;
            dir_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ph_q        <= ph_d;
            cur_q       <= cur_d;
            eff_min_q   <= eff_min_d;
            eff_start_q <= eff_start_d;
            accel_q     <= accel_d;
            steps_q     <= steps_d;
            cnt_q       <= cnt_d;
            ramp_q      <= ramp_d;
            dir_q       <= dir_d;
            done_q      <= done_d;
        end
    end

    assign CP         = (state_q != IDLE) && (ph_q < PER_W'(PULSE_W));
    assign CCW        = dir_q;
    assign busy       = (state_q != IDLE);
    assign done       = done_q;
    assign steps_done = cnt_q;

endmodule

// File: tb/tb_step_profile_ctrl.sv
// Directed bench for step_profile_ctrl: one 16-bit instance (PULSE_W=2) and one
// narrow 8-bit-period instance (PULSE_W=4) used for clamp and saturation cases.
module tb_step_profile_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_a, start_b, abort, dir_in;
    logic [15:0] steps, sp, mp;
    logic [7:0]  acc;
    logic        cp_a, ccw_a, busy_a, done_a;
    logic        cp_b, ccw_b, busy_b, done_b;
    logic [15:0] sd_a, sd_b;
    logic        sel;
    logic        cp_m, ccw_m, busy_m, done_m;
    logic [15:0] sd_m;

    int n_cmp = 0;
    int n_bad = 0;
    int rises[$];
    int done_off, ndone, busy_cnt, cp_cnt, cp_after;

    always #5 clk = ~clk;

    step_profile_ctrl #(.STEP_W(16), .PER_W(16), .ACC_W(8), .PULSE_W(2)) dut_a (
        .CLK(clk), .rst(rst), .start(start_a), .abort(abort), .dir_in(dir_in),
        .steps(steps), .start_period(sp), .min_period(mp), .accel(acc),
        .CP(cp_a), .CCW(ccw_a), .busy(busy_a), .done(done_a), .steps_done(sd_a)
    );

    step_profile_ctrl #(.STEP_W(16), .PER_W(8), .ACC_W(8), .PULSE_W(4)) dut_b (
        .CLK(clk), .rst(rst), .start(start_b), .abort(abort), .dir_in(dir_in),
        .steps(steps), .start_period(sp[7:0]), .min_period(mp[7:0]), .accel(acc),
        .CP(cp_b), .CCW(ccw_b), .busy(busy_b), .done(done_b), .steps_done(sd_b)
    );

    assign cp_m   = sel ? cp_b   : cp_a;
    assign ccw_m  = sel ? ccw_b  : ccw_a;
    assign busy_m = sel ? busy_b : busy_a;
    assign done_m = sel ? done_b : done_a;
    assign sd_m   = sel ? sd_b   : sd_a;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Start is accepted on the posedge between the two negedges; returns at offset 0 (t+1)
    task automatic launch(input logic s, input logic d, input int n, input int spv,
                          input int mpv, input int accv);
        @(negedge clk);
        sel    = s;
        dir_in = d;
        steps  = 16'(n);
        sp     = 16'(spv);
        mp     = 16'(mpv);
        acc    = 8'(accv);
        if (s) start_b = 1'b1;
        else   start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    // kind 1: raise abort at inj_at; kind 2: pulse a conflicting start at inj_at
    task automatic capture(input int budget, input int inj_at, input int kind);
        logic prev;
        prev = 1'b0;
        rises.delete();
        done_off = -1; ndone = 0; busy_cnt = 0; cp_cnt = 0; cp_after = 0;
        for (int i = 0; i < budget; i++) begin
            if (cp_m && !prev) rises.push_back(i);
            prev = cp_m;
            if (busy_m) busy_cnt++;
            if (cp_m) begin
                cp_cnt++;
                if (done_off >= 0) cp_after++;
            end
            if (done_m) begin
                ndone++;
                if (done_off < 0) done_off = i;
            end
            if (i == inj_at && kind == 1) abort = 1'b1;
            if (i == inj_at && kind == 2) begin
                start_a = 1'b1;
                steps   = 16'd50;
                dir_in  = ~dir_in;
            end
            if (i == inj_at + 1 && kind == 2) start_a = 1'b0;
            if (done_off >= 0 && i >= done_off + 4) break;
            @(negedge clk);
        end
        abort   = 1'b0;
        start_a = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: observed hang expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0; start_a = 1'b0; start_b = 1'b0; abort = 1'b0; dir_in = 1'b0;
        steps = '0; sp = '0; mp = '0; acc = '0; sel = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_cp", cp_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_done", done_a, 0);
        check("rst_steps_done", sd_a, 0);
        check("rst_ccw", ccw_a, 0);
        rst = 1'b1;
        @(negedge clk);

        // Basic profile: periods 10, 8, 6, 8
        launch(1'b0, 1'b1, 4, 10, 6, 2);
        check("basic_busy_t1", busy_m, 1);
        check("basic_ccw", ccw_m, 1);
        capture(200, -1, 0);
        check("basic_nrise", rises.size(), 4);
        check("basic_rise0", rises[0], 0);
        check("basic_rise1", rises[1], 10);
        check("basic_rise2", rises[2], 18);
        check("basic_rise3", rises[3], 24);
        check("basic_done_at", done_off, 32);
        check("basic_ndone", ndone, 1);
        check("basic_busy_cycles", busy_cnt, 32);
        check("basic_cp_high", cp_cnt, 8);
        check("basic_steps_done", sd_m, 4);

        // steps=0: immediate done, never busy
        launch(1'b0, 1'b1, 0, 10, 6, 2);
        capture(20, -1, 0);
        check("zero_done_at", done_off, 0);
        check("zero_ndone", ndone, 1);
        check("zero_busy", busy_cnt, 0);
        check("zero_nrise", rises.size(), 0);
        check("zero_steps_done", sd_m, 0);

        // min_period above start_period: flat 20
        launch(1'b0, 1'b0, 3, 10, 20, 2);
        capture(200, -1, 0);
        check("minhi_nrise", rises.size(), 3);
        check("minhi_rise1", rises[1], 20);
        check("minhi_rise2", rises[2], 40);
        check("minhi_done_at", done_off, 60);
        check("minhi_ccw", ccw_m, 0);

        // PULSE_W=4 floor: min=1, start=3 -> flat 8
        launch(1'b1, 1'b0, 3, 3, 1, 1);
        capture(200, -1, 0);
        check("floor_nrise", rises.size(), 3);
        check("floor_rise1", rises[1], 8);
        check("floor_rise2", rises[2], 16);
        check("floor_done_at", done_off, 24);
        check("floor_cp_high", cp_cnt, 12);

        // 8-bit periods: 255 - 255 clamps to 16, 16 + 255 clamps to 255
        launch(1'b1, 1'b0, 3, 255, 16, 255);
        capture(700, -1, 0);
        check("sat_nrise", rises.size(), 3);
        check("sat_rise1", rises[1], 255);
        check("sat_rise2", rises[2], 271);
        check("sat_done_at", done_off, 526);
        check("sat_steps_done", sd_m, 3);

        // Abort in the middle of step 5 (offsets 30..35)
        launch(1'b0, 1'b1, 100, 10, 6, 2);
        capture(200, 32, 1);
        check("abort_nrise", rises.size(), 5);
        check("abort_rise4", rises[4], 30);
        check("abort_done_at", done_off, 36);
        check("abort_ndone", ndone, 1);
        check("abort_steps_done", sd_m, 5);
        check("abort_cp_after", cp_after, 0);

        // Start while busy is ignored
        launch(1'b0, 1'b0, 3, 10, 6, 2);
        capture(200, 5, 2);
        check("busy_start_nrise", rises.size(), 3);
        check("busy_start_rise2", rises[2], 18);
        check("busy_start_done_at", done_off, 28);
        check("busy_start_ndone", ndone, 1);
        check("busy_start_steps_done", sd_m, 3);
        check("busy_start_ccw", ccw_m, 0);

        // Reset mid-move
        launch(1'b0, 1'b1, 100, 10, 6, 2);
        repeat (15) @(negedge clk);
        check("midrst_busy_before", busy_a, 1);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_cp", cp_a, 0);
        check("midrst_busy", busy_a, 0);
        check("midrst_done", done_a, 0);
        check("midrst_steps_done", sd_a, 0);
        capture(30, -1, 0);
        check("midrst_ndone", ndone, 0);
        check("midrst_nrise", rises.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
